player_motion_ctrl: RTL and testbench
=====================================

Name: player_motion_ctrl

Overview:
- Parametrised, multi-player successor of the single-frame sprite mover.
- Once every FRAME_DIV frames, on the rising edge of the end-of-frame strobe, it samples every player's direction keys and updates each player's top-left position in turn, one player per clock.
- Moves use a configurable step and are clamped to a configurable playfield.
- Also outputs facing direction and a moving flag for sprite animation, plus an update-done pulse for downstream collision/bomb logic.

Parameters:
- NP, 2, number of players (1..8)
- CW, 11, signed coordinate width
- X_MIN, 0, minimum legal x (inclusive)
- X_MAX, 768, maximum legal x (inclusive; 800 - 32 sprite width)
- Y_MIN, 0, minimum legal y (inclusive)
- Y_MAX, 568, maximum legal y (inclusive; 600 - 32)
- STEP, 1, pixels moved per update (1..31)
- FRAME_DIV, 1, frames per update (>=1)
- DIAG, 1, 1 = diagonal moves allowed; 0 = horizontal has priority
- SPAWN_X, 400, reset x of player 0
- SPAWN_DX, 64, reset x offset per player index
- SPAWN_Y, 300, reset y of all players

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- eof  in  1  end-of-frame level from video timing; may stay high several cycles
- keys  in  4*NP  per player i, bits [4i+3:4i] = {right,left,down,up}, active high
- pos_x  out  NP*CW  signed x of player i at [CW*i+CW-1:CW*i]
- pos_y  out  NP*CW  signed y, same packing
- dir  out  2*NP  facing of player i: 0 up, 1 down, 2 left, 3 right
- moving  out  NP  player i position changed at last update
- update_done  out  1  one-cycle pulse after the last player is updated

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset values:
  - pos_x[i] = SPAWN_X + i*SPAWN_DX, clamped to [X_MIN, X_MAX]
  - pos_y[i] = SPAWN_Y, clamped to [Y_MIN, Y_MAX]
  - dir = 1 (down) for every player
  - moving = 0, update_done = 0
  - FSM = IDLE, frame counter = 0, eof_q = 0, key snapshot = 0
- Edge detect: eof_q registers eof; tick = eof & ~eof_q. Exactly one tick per eof high period.
- Frame counter fc, 0..FRAME_DIV-1:
  - On a tick: if fc == FRAME_DIV-1, then fc <= 0 and a move request (req) is raised; else fc <= fc+1.
  - FRAME_DIV = 1 gives a req on every tick.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on req, snapshot all keys, idx <= 0, go to SCAN.
  - SCAN: update player idx from the snapshot. If idx == NP-1 go to DONE; else idx++.
  - DONE: update_done = 1 for this cycle only, then go to IDLE.
  - A req arriving outside IDLE is dropped; fc still advances.
- Latency: with the tick sampled at edge k, player i's outputs change at edge k+1+i. update_done is high in the cycle after edge k+NP.
- Per-player update, all arithmetic in CW+1 signed bits:
  - up & down both set: no y request. left & right both set: no x request.
  - DIAG = 0 with both an x and a y request: only x moves.
  - x request: nx = x ± STEP, clamped to [X_MIN, X_MAX]. y request: ny = y ± STEP, clamped to [Y_MIN, Y_MAX].
  - moving[i] = 1 iff (nx,ny) != (x,y). A key held against a wall gives moving = 0.
  - dir[i]: if x changed, left/right; else if y changed, up/down; else unchanged. With DIAG = 1 and both axes changed, horizontal wins.
  - moving and dir hold until that player's next update.
- Players not being scanned keep all their outputs.
- Key changes after the snapshot have no effect on the current update.
- reset asserted mid-SCAN: all outputs return to reset values on the next edge; no partial update survives.

Test Plan:
- NP=2, reset, then eof pulse 3 cycles long with j0 right and j1 up held -> one update only. Edge k+1: pos_x0 = 401, dir0 = 3, moving0 = 1. Edge k+2: pos_y1 = 299, dir1 = 0. update_done pulses once.
- j0 left held with pos_x0 = 0, STEP = 4 -> pos_x0 stays 0, moving0 = 0, dir0 unchanged. Start from pos_x0 = 2 -> result 0 (clamped), not -2.
- j0 up+down+right held, DIAG = 0 -> x = +STEP, y unchanged, dir0 = 3. Same keys with DIAG = 1 -> identical result, since up/down cancel.
- FRAME_DIV = 3, eof pulsed 6 times with j1 down -> pos_y1 changes only on the 3rd and 6th pulse: 300 -> 301 -> 302.
- Keys change between eof rise and edge k+2 -> player 1 moves per the snapshotted keys. A second eof rise during SCAN (NP = 8) is dropped.
- reset asserted during SCAN at idx 1 -> next edge: all positions at spawn, dir = 1, update_done = 0, FSM IDLE.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// Multi-player sprite mover: once every FRAME_DIV frames, steps each player's
// top-left position from a key snapshot, one player per clock, clamped to the playfield.
module player_motion_ctrl #(
  parameter int unsigned NP        = 2,
  parameter int unsigned CW        = 11,
  parameter int          X_MIN     = 0,
  parameter int          X_MAX     = 768,
  parameter int          Y_MIN     = 0,
  parameter int          Y_MAX     = 568,
  parameter int unsigned STEP      = 1,
  parameter int unsigned FRAME_DIV = 1,
  parameter bit          DIAG      = 1'b1,
  parameter int          SPAWN_X   = 400,
  parameter int          SPAWN_DX  = 64,
  parameter int          SPAWN_Y   = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               eof,
  input  logic [4*NP-1:0]    keys,
  output logic [NP*CW-1:0]   pos_x,
  output logic [NP*CW-1:0]   pos_y,
  output logic [2*NP-1:0]    dir,
  output logic [NP-1:0]      moving,
  output logic               update_done
);

  localparam int unsigned AW = CW + 1;
  localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef logic signed [AW-1:0] crd_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam crd_t XLO = AW'(X_MIN);
  localparam crd_t XHI = AW'(X_MAX);
  localparam crd_t YLO = AW'(Y_MIN);
  localparam crd_t YHI = AW'(Y_MAX);
  localparam crd_t STP = AW'(STEP);

  function automatic crd_t clamp(input crd_t v, input crd_t lo, input crd_t hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic crd_t spawn_x(input int i);
    return clamp(AW'(SPAWN_X + i * SPAWN_DX), XLO, XHI);
  endfunction

  state_t                 state_q, state_nx;
  logic [IW-1:0]          idx_q, idx_nx;
  logic [FW-1:0]          fc_q, fc_nx;
  logic                   eof_q;
  logic [4*NP-1:0]        snap_q, snap_nx;
  logic                   done_q, done_nx;
  logic signed [CW-1:0]   px_q [NP];
  logic signed [CW-1:0]   py_q [NP];
  logic [1:0]             dir_q [NP];
  logic [NP-1:0]          mov_q;

  logic                   tick_c, req_c;
  logic [3:0]             k_c;
  logic                   xreq_c, yreq_c, xchg_c, ychg_c;
  crd_t                   cx_c, cy_c, nx_c, ny_c;
  logic [1:0]             ndir_c;

  // Frame divider and scan sequencing
  always_comb begin
    state_nx = state_q;
    idx_nx   = idx_q;
    snap_nx  = snap_q;
    fc_nx    = fc_q;
    done_nx  = 1'b0;
    req_c    = 1'b0;
    tick_c   = eof & ~eof_q;
    if (tick_c) begin
      if (fc_q == FW'(FRAME_DIV - 1)) begin
        fc_nx = '0;
        req_c = 1'b1;
      end else begin
        fc_nx = fc_q + 1'b1;
      end
    end
    case (state_q)
      IDLE: begin
        if (req_c) begin
          snap_nx  = keys;
          idx_nx   = '0;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IW'(NP - 1)) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          idx_nx = idx_q + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next position/facing of the player currently selected by idx_q
  always_comb begin
    k_c    = snap_q[4*idx_q +: 4];
    cx_c   = AW'(px_q[idx_q]);
    cy_c   = AW'(py_q[idx_q]);
    xreq_c = k_c[2] ^ k_c[3];
    yreq_c = (k_c[0] ^ k_c[1]) & (DIAG | ~xreq_c);
    nx_c   = cx_c;
    ny_c   = cy_c;
    if (xreq_c) nx_c = clamp(k_c[3] ? cx_c + STP : cx_c - STP, XLO, XHI);
    if (yreq_c) ny_c = clamp(k_c[1] ? cy_c + STP : cy_c - STP, YLO, YHI);
    xchg_c = (nx_c != cx_c);
    ychg_c = (ny_c != cy_c);
    if (xchg_c)      ndir_c = k_c[3] ? 2'd3 : 2'd2;
    else if (ychg_c) ndir_c = k_c[1] ? 2'd1 : 2'd0;
    else             ndir_c = dir_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fc_q    <= '0;
      eof_q   <= 1'b0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      mov_q   <= '0;
      for (int i = 0; i < int'(NP); i++) begin
        px_q[i]  <= CW'(spawn_x(i));
        py_q[i]  <= CW'(clamp(AW'(SPAWN_Y), YLO, YHI));
        dir_q[i] <= 2'd1;
      end
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
      fc_q    <= fc_nx;
      eof_q   <= eof;
      snap_q  <= snap_nx;
      done_q  <= done_nx;
      if (state_q == SCAN) begin
        for (int i = 0; i < int'(NP); i++) begin
          if (idx_q == IW'(i)) begin
            px_q[i]  <= CW'(nx_c);
            py_q[i]  <= CW'(ny_c);
            dir_q[i] <= ndir_c;
            mov_q[i] <= xchg_c | ychg_c;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NP); g++) begin : g_pack
    assign pos_x[CW*g +: CW] = px_q[g];
    assign pos_y[CW*g +: CW] = py_q[g];
    assign dir[2*g +: 2]     = dir_q[g];
  end

  assign moving      = mov_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: four differently parametrised instances,
// a behavioural model pushes expected results on each accepted frame request.
module tb_player_motion_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic eof0, eof1, eof2, eof3;
  logic [7:0]  keys0;
  logic [3:0]  keys1;
  logic [7:0]  keys2;
  logic [31:0] keys3;
  logic [21:0] pos_x0, pos_y0, pos_x2, pos_y2;
  logic [10:0] pos_x1, pos_y1;
  logic [87:0] pos_x3, pos_y3;
  logic [3:0]  dir0, dir2;
  logic [1:0]  dir1;
  logic [15:0] dir3;
  logic [1:0]  moving0, moving2;
  logic [0:0]  moving1;
  logic [7:0]  moving3;
  logic        update_done0, update_done1, update_done2, update_done3;

  player_motion_ctrl #(.NP(2)) u_dut0 (
    .clk(clk), .reset(reset), .eof(eof0), .keys(keys0), .pos_x(pos_x0), .pos_y(pos_y0),
    .dir(dir0), .moving(moving0), .update_done(update_done0));

  player_motion_ctrl #(.NP(1), .STEP(4), .SPAWN_X(2), .DIAG(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .eof(eof1), .keys(keys1), .pos_x(pos_x1), .pos_y(pos_y1),
    .dir(dir1), .moving(moving1), .update_done(update_done1));

  player_motion_ctrl #(.NP(2), .FRAME_DIV(3)) u_dut2 (
    .clk(clk), .reset(reset), .eof(eof2), .keys(keys2), .pos_x(pos_x2), .pos_y(pos_y2),
    .dir(dir2), .moving(moving2), .update_done(update_done2));

  player_motion_ctrl #(.NP(8)) u_dut3 (
    .clk(clk), .reset(reset), .eof(eof3), .keys(keys3), .pos_x(pos_x3), .pos_y(pos_y3),
    .dir(dir3), .moving(moving3), .update_done(update_done3));

  // Instance configuration as seen by the model
  int np_a[4]   = '{2, 1, 2, 8};
  int step_a[4] = '{1, 4, 1, 1};
  int diag_a[4] = '{1, 0, 1, 1};
  int div_a[4]  = '{1, 1, 3, 1};
  int spx_a[4]  = '{400, 2, 400, 400};

  int mx[4][8], my[4][8], md[4][8], mm[4][8];
  int fc_m[4];

  typedef struct {
    int          id;
    logic [87:0] px;
    logic [87:0] py;
    logic [15:0] d;
    logic [7:0]  m;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 4; id++) begin
      fc_m[id] = 0;
      for (int i = 0; i < 8; i++) begin
        mx[id][i] = clampi(spx_a[id] + 64 * i, 0, 768);
        my[id][i] = 300;
        md[id][i] = 1;
        mm[id][i] = 0;
      end
    end
  endtask

  task automatic model_step(input int id, input logic [31:0] k);
    for (int i = 0; i < np_a[id]; i++) begin
      logic [3:0] kk;
      int dx, dy, nx, ny;
      kk = k[4*i +: 4];
      dx = 0;
      dy = 0;
      if (kk[3] && !kk[2]) dx = step_a[id];
      if (kk[2] && !kk[3]) dx = -step_a[id];
      if (kk[1] && !kk[0]) dy = step_a[id];
      if (kk[0] && !kk[1]) dy = -step_a[id];
      if (diag_a[id] == 0 && dx != 0) dy = 0;
      nx = clampi(mx[id][i] + dx, 0, 768);
      ny = clampi(my[id][i] + dy, 0, 568);
      mm[id][i] = (nx != mx[id][i] || ny != my[id][i]) ? 1 : 0;
      if (nx != mx[id][i])      md[id][i] = (nx > mx[id][i]) ? 3 : 2;
      else if (ny != my[id][i]) md[id][i] = (ny > my[id][i]) ? 1 : 0;
      mx[id][i] = nx;
      my[id][i] = ny;
    end
  endtask

  function automatic exp_t build_exp(input int id);
    exp_t e;
    e.id = id;
    e.px = '0;
    e.py = '0;
    e.d  = '0;
    e.m  = '0;
    for (int i = 0; i < np_a[id]; i++) begin
      e.px[i*11 +: 11] = 11'(mx[id][i]);
      e.py[i*11 +: 11] = 11'(my[id][i]);
      e.d[i*2 +: 2]    = 2'(md[id][i]);
      e.m[i]           = mm[id][i][0];
    end
    return e;
  endfunction

  function automatic logic [31:0] cur_keys(input int id);
    case (id)
      0:       return 32'(keys0);
      1:       return 32'(keys1);
      2:       return 32'(keys2);
      default: return keys3;
    endcase
  endfunction

  task automatic set_eof(input int id, input logic v);
    case (id)
      0:       eof0 = v;
      1:       eof1 = v;
      2:       eof2 = v;
      default: eof3 = v;
    endcase
  endtask

  task automatic get_out(input int id, output logic [87:0] gx, output logic [87:0] gy,
                         output logic [15:0] gd, output logic [7:0] gm);
    case (id)
      0:       begin gx = 88'(pos_x0); gy = 88'(pos_y0); gd = 16'(dir0); gm = 8'(moving0); end
      1:       begin gx = 88'(pos_x1); gy = 88'(pos_y1); gd = 16'(dir1); gm = 8'(moving1); end
      2:       begin gx = 88'(pos_x2); gy = 88'(pos_y2); gd = 16'(dir2); gm = 8'(moving2); end
      default: begin gx = pos_x3;      gy = pos_y3;      gd = dir3;      gm = moving3;      end
    endcase
  endtask

  task automatic cmp_out(input int id, input exp_t e, input string tag);
    logic [87:0] gx, gy;
    logic [15:0] gd;
    logic [7:0]  gm;
    get_out(id, gx, gy, gd, gm);
    chk({tag, "_px"}, 96'(gx), 96'(e.px));
    chk({tag, "_py"}, 96'(gy), 96'(e.py));
    chk({tag, "_dir"}, 96'(gd), 96'(e.d));
    chk({tag, "_mov"}, 96'(gm), 96'(e.m));
  endtask

  task automatic push_req(input int id);
    model_step(id, cur_keys(id));
    sbq.push_back(build_exp(id));
  endtask

  // One eof high period of len cycles followed by gap idle cycles
  task automatic frame(input int id, input int len, input int gap);
    fc_m[id]++;
    if (fc_m[id] == div_a[id]) begin
      fc_m[id] = 0;
      push_req(id);
    end
    set_eof(id, 1'b1);
    repeat (len) @(negedge clk);
    set_eof(id, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  // Scoreboard consumer: every update_done pulse must match the oldest expectation
  always @(negedge clk) begin
    logic [3:0] ud;
    ud = {update_done3, update_done2, update_done1, update_done0};
    for (int id = 0; id < 4; id++) begin
      if (ud[id]) begin
        if (sbq.size() == 0) begin
          chk("sb_extra_done", 96'(id + 1), 96'(0));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_id", 96'(id), 96'(e.id));
          cmp_out(id, e, "sb");
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    {eof0, eof1, eof2, eof3} = '0;
    keys0 = '0; keys1 = '0; keys2 = '0; keys3 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int id = 0; id < 4; id++) cmp_out(id, build_exp(id), "rst");
    chk("rst_done", 96'({update_done3, update_done2, update_done1, update_done0}), 96'(0));
    chk("rst_x3_p7", 96'(pos_x3[87:77]), 96'(768));
    reset = 1'b0;
    @(negedge clk);

    // Per-player latency with a 3-cycle eof: j0 right, j1 up
    keys0 = 8'b0001_1000;
    push_req(0);
    eof0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_x0", 96'(pos_x0[10:0]), 96'(401));
    chk("lat_dir0", 96'(dir0[1:0]), 96'(3));
    chk("lat_mov0", 96'(moving0[0]), 96'(1));
    chk("lat_y1_hold", 96'(pos_y0[21:11]), 96'(300));
    chk("lat_done_early", 96'(update_done0), 96'(0));
    @(negedge clk);
    chk("lat_y1", 96'(pos_y0[21:11]), 96'(299));
    chk("lat_dir1", 96'(dir0[3:2]), 96'(0));
    chk("lat_done", 96'(update_done0), 96'(1));
    eof0 = 1'b0;
    repeat (5) @(negedge clk);

    // Opposing vertical keys cancel; with DIAG both axes move and horizontal sets facing
    keys0 = 8'b0000_1011;
    frame(0, 1, 5);
    chk("ud_cancel_x0", 96'(pos_x0[10:0]), 96'(402));
    chk("ud_cancel_y0", 96'(pos_y0[10:0]), 96'(300));
    keys0 = 8'b0000_1001;
    frame(0, 1, 5);
    chk("diag_y0", 96'(pos_y0[10:0]), 96'(299));
    chk("diag_dir0", 96'(dir0[1:0]), 96'(3));

    // Wall clamp with STEP 4 starting at x = 2, DIAG = 0
    keys1 = 4'b0100;
    frame(1, 1, 4);
    chk("clamp_x", 96'(pos_x1), 96'(0));
    chk("clamp_mov", 96'(moving1), 96'(1));
    frame(1, 1, 4);
    chk("wall_x", 96'(pos_x1), 96'(0));
    chk("wall_mov", 96'(moving1), 96'(0));
    chk("wall_dir", 96'(dir1), 96'(2));
    keys1 = 4'b1011;
    frame(1, 1, 4);
    chk("nodiag_cancel_x", 96'(pos_x1), 96'(4));
    chk("nodiag_cancel_dir", 96'(dir1), 96'(3));
    keys1 = 4'b1001;
    frame(1, 1, 4);
    chk("nodiag_x", 96'(pos_x1), 96'(8));
    chk("nodiag_y", 96'(pos_y1), 96'(300));
    keys1 = 4'b0001;
    frame(1, 1, 4);
    chk("up_y", 96'(pos_y1), 96'(296));
    chk("up_dir", 96'(dir1), 96'(0));

    // FRAME_DIV = 3: only every third eof moves player 1 down
    keys2 = 8'b0010_0000;
    for (int p = 1; p <= 6; p++) begin
      frame(2, 1, 5);
      chk("fdiv_y1", 96'(pos_y2[21:11]), 96'(300 + p / 3));
    end

    // Keys changed after the snapshot edge do not affect the running update
    keys0 = 8'b0100_0000;
    push_req(0);
    eof0 = 1'b1;
    @(negedge clk);
    keys0 = 8'b1000_0000;
    eof0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("snap_x1", 96'(pos_x0[21:11]), 96'(463));
    keys0 = 8'b0000_0000;

    // Second eof rise during an 8-player scan is dropped
    keys3 = 32'h8888_8888;
    push_req(3);
    eof3 = 1'b1;
    @(negedge clk);
    eof3 = 1'b0;
    repeat (2) @(negedge clk);
    eof3 = 1'b1;
    @(negedge clk);
    eof3 = 1'b0;
    repeat (14) @(negedge clk);
    chk("drop_x0", 96'(pos_x3[10:0]), 96'(401));
    chk("drop_wall_mov6", 96'(moving3[6]), 96'(0));

    // Reset in the middle of a scan (idx 1) restores spawn state
    eof3 = 1'b1;
    @(negedge clk);
    eof3 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    cmp_out(3, build_exp(3), "rst_scan");
    cmp_out(0, build_exp(0), "rst_scan0");
    chk("rst_scan_done", 96'(update_done3), 96'(0));
    reset = 1'b0;
    repeat (12) @(negedge clk);
    frame(3, 1, 12);

    // Random key patterns on the two-player instance
    repeat (8) begin
      keys0 = 8'($urandom);
      frame(0, 1 + int'($urandom_range(0, 2)), 5);
    end

    chk("sb_empty", 96'(sbq.size()), 96'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
